// File: rtl/median_pkg.sv
// median_pkg: shared constants, state encoding and counter type for the
// sequential median filter (median_seq) and its sorting engine (MED).
package median_pkg;

  // One window holds a 3x3 neighbourhood
  localparam int PIX_NB      = 9;
  // Max-extraction passes needed to reach the 5th largest value
  localparam int PASS_NB     = 5;
  // Passes 0..3 take PIX_NB cycles each, the last pass PIX_NB-PASS_NB cycles
  localparam int SORT_CYCLES = 40;

  // Wide enough for the longest count in a window, so nothing ever wraps
  localparam int CNT_W = $clog2(SORT_CYCLES + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  // Last pixel index, last pass index and last step of the final pass
  localparam cnt_t PIX_LAST   = cnt_t'(PIX_NB - 1);
  localparam cnt_t PASS_LAST  = cnt_t'(PASS_NB - 1);
  localparam cnt_t FINAL_LAST = cnt_t'(PIX_NB - PASS_NB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SORT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Bypass schedule inside a sort pass: pass p compares for its first
  // PIX_NB-1-p steps, then rotates the already-extracted maxima past the
  // compare element so they stay out of later comparisons.
  function automatic logic sort_byp(input cnt_t pass, input cnt_t step);
    return (step >= (PIX_LAST - pass));
  endfunction

endpackage

// File: rtl/median_seq_med.sv
// MED: ring of `number` pixel registers with a single min/max compare
// element between the last two stages. BYP=1 plain rotation; BYP=0 keeps
// the larger value in the last stage and recirculates the smaller one.
// DSI=1 feeds DI into the first stage instead of the recirculated value.
// The ring registers carry no reset: their content is only meaningful
// after a full window has been loaded.
module MED #(
  parameter int width  = 8,
  parameter int number = 9
) (
  input  logic             CLK,
  input  logic [width-1:0] DI,
  input  logic             DSI,
  input  logic             BYP,
  output logic [width-1:0] DO
);

  logic [width-1:0] ring [number];
  logic [width-1:0] cmp_max;
  logic [width-1:0] cmp_min;

  // Compare element between the last two ring stages
  always_comb begin
    cmp_max = ring[number-1];
    cmp_min = ring[number-2];
    if (ring[number-2] > ring[number-1]) begin
      cmp_max = ring[number-2];
      cmp_min = ring[number-1];
    end
  end

  // Ring shift: head takes a new pixel or the recirculated value, tail takes
  // either the plain shift or the running maximum
  always_ff @(posedge CLK) begin
    if (DSI) begin
      ring[0] <= DI;
    end else if (BYP) begin
      ring[0] <= ring[number-1];
    end else begin
      ring[0] <= cmp_min;
    end
    for (int i = 1; i < number - 1; i++) begin
      ring[i] <= ring[i-1];
    end
    if (BYP) begin
      ring[number-1] <= ring[number-2];
    end else begin
      ring[number-1] <= cmp_max;
    end
  end

  assign DO = ring[number-1];

endmodule

// File: rtl/median_seq.sv
// median_seq: collects a 9-pixel window strobed by DSI, sorts it in the MED
// engine and pulses DSO for one cycle with the window median on DO,
// 41 cycles after the 9th pixel.
// Defining MEDIAN_SEQ_BUSY_EN adds a BUSY output that is high from the
// first pixel of a window until the end of its DSO cycle.
module median_seq
  import median_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] DI,
  input  logic             DSI,
  output logic [WIDTH-1:0] DO,
  output logic             DSO
`ifdef MEDIAN_SEQ_BUSY_EN
  ,
  output logic             BUSY
`endif
);

  state_t state;
  state_t state_nx;
  cnt_t   pix_cnt;
  cnt_t   pix_nx;
  cnt_t   pass_cnt;
  cnt_t   pass_nx;
  cnt_t   step_cnt;
  cnt_t   step_nx;
  logic   eng_dsi;
  logic   eng_byp;

  MED #(
    .width (WIDTH),
    .number(PIX_NB)
  ) u_med (
    .CLK(CLK),
    .DI (DI),
    .DSI(eng_dsi),
    .BYP(eng_byp),
    .DO (DO)
  );

  // Control state and counters; reset abandons any window in progress
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      pix_cnt  <= '0;
      pass_cnt <= '0;
      step_cnt <= '0;
    end else begin
      state    <= state_nx;
      pix_cnt  <= pix_nx;
      pass_cnt <= pass_nx;
      step_cnt <= step_nx;
    end
  end

  // Next state, counter updates and engine control for each phase
  always_comb begin
    state_nx = state;
    pix_nx   = pix_cnt;
    pass_nx  = pass_cnt;
    step_nx  = step_cnt;
    eng_dsi  = 1'b0;
    eng_byp  = 1'b1;
    DSO      = 1'b0;
    case (state)
      IDLE: begin
        eng_dsi = DSI;
        pix_nx  = '0;
        pass_nx = '0;
        step_nx = '0;
        if (DSI) begin
          pix_nx   = cnt_t'(1);
          state_nx = LOAD;
        end
      end
      LOAD: begin
        eng_dsi = 1'b1;
        if (!DSI) begin
          pix_nx   = '0;
          state_nx = IDLE;
        end else if (pix_cnt == PIX_LAST) begin
          pix_nx   = '0;
          pass_nx  = '0;
          step_nx  = '0;
          state_nx = SORT;
        end else begin
          pix_nx = pix_cnt + cnt_t'(1);
        end
      end
      SORT: begin
        eng_byp = sort_byp(pass_cnt, step_cnt);
        if ((pass_cnt == PASS_LAST) && (step_cnt == FINAL_LAST)) begin
          pass_nx  = '0;
          step_nx  = '0;
          state_nx = DONE;
        end else if (step_cnt == PIX_LAST) begin
          pass_nx = pass_cnt + cnt_t'(1);
          step_nx = '0;
        end else begin
          step_nx = step_cnt + cnt_t'(1);
        end
      end
      DONE: begin
        DSO      = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

`ifdef MEDIAN_SEQ_BUSY_EN
  // Busy whenever a window is being loaded, sorted or delivered
  always_comb begin
    BUSY = (state != IDLE);
  end
`endif

endmodule
